// File: rtl/tlc_pkg.sv
// Shared definitions for the highway/country traffic-light scheduler.
//   - Colour codes driven on the hwy/cntry outputs.
//   - tlc_phase_t: 3-bit phase encoding, also exported on the phase output.
//   - tlc_colours(): maps a phase encoding to {hwy, cntry}.
package tlc_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef enum logic [2:0] {
        StHg  = 3'd0,
        StHy  = 3'd1,
        StAr1 = 3'd2,
        StCg  = 3'd3,
        StCy  = 3'd4,
        StAr2 = 3'd5
    } tlc_phase_t;

    // Returns {hwy, cntry}. Unused encodings show all-red.
    function automatic logic [3:0] tlc_colours(input logic [2:0] st);
        logic [3:0] c;
        case (st)
            StHg:    c = {GREEN, RED};
            StHy:    c = {YELLOW, RED};
            StCg:    c = {RED, GREEN};
            StCy:    c = {RED, YELLOW};
            default: c = {RED, RED};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts tick pulses elapsed in the current phase.
//   clk      - clock
//   clear_n  - synchronous active-low reset
//   clr_i    - synchronous clear (phase change), wins over tick_i
//   tick_i   - count enable, one-cycle pulse
//   count_o  - ticks elapsed, saturates at all-ones
module tlc_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             clr_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tlc_phase_sched.sv
// Timed phase scheduler for the highway/country intersection.
// Sequences HG -> HY -> AR1 -> CG -> CY -> AR2 -> HG on the shared tick timebase,
// latches country-road (and optionally pedestrian) demand and enforces min/max green.
//   clk      - clock
//   clear_n  - synchronous active-low reset (returns to HG immediately)
//   tick     - timebase enable, one-cycle pulse
//   x        - country-road vehicle sensor, level
//   ped_req  - pedestrian request, level or pulse
//   hwy      - highway colour (0 red, 1 yellow, 2 green)
//   cntry    - country colour, same encoding
//   walk     - pedestrian walk indication (registered)
//   phase    - current state encoding
// Build option: define TLC_PED_EN to include the pedestrian path; otherwise ped_req is
// ignored and walk is tied low.
module tlc_phase_sched
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 10,
    parameter int unsigned GREEN_MAX = 30,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       tick,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic [2:0] phase
);

    localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

    if (GREEN_MIN == 0 || GREEN_MIN >= GREEN_MAX || 64'(GREEN_MAX) > CntMax) begin : g_bad_green
        $error("tlc_phase_sched: need 1 <= GREEN_MIN < GREEN_MAX < 2**CNT_W");
    end
    if (YELLOW_T == 0 || ALLRED_T == 0) begin : g_bad_timing
        $error("tlc_phase_sched: YELLOW_T and ALLRED_T must be at least 1");
    end

    // Transitions compare the pre-increment count, so "duration N" means count == N-1.
    localparam logic [CNT_W-1:0] GMinM1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMaxM1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YelM1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ArM1   = CNT_W'(ALLRED_T - 1);

    logic [2:0]       state_d, state_q;
    logic [CNT_W-1:0] timer;
    logic             x_lat_d, x_lat_q;
    logic             demand;
    logic [CNT_W-1:0] cg_min;
    logic             enter_cg, leave_cg;

`ifdef TLC_PED_EN
    // With walk active the country green is held for twice the minimum; clamp to the
    // counter range (GREEN_MAX, which is always representable, still ends it).
    localparam longint unsigned WalkRaw   = 2 * 64'(GREEN_MIN) - 64'd1;
    localparam logic [CNT_W-1:0] WalkMinM1 = CNT_W'((WalkRaw > CntMax) ? CntMax : WalkRaw);

    logic ped_lat_d, ped_lat_q;
    logic walk_d, walk_q;

    assign demand = x_lat_q | ped_lat_q;
    assign cg_min = walk_q ? WalkMinM1 : GMinM1;

    always_comb begin
        ped_lat_d = enter_cg ? 1'b0 : (ped_lat_q | ped_req);
        walk_d    = walk_q;
        if (enter_cg) begin
            walk_d = ped_lat_q;
        end else if (leave_cg) begin
            walk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            ped_lat_q <= 1'b0;
            walk_q    <= 1'b0;
        end else begin
            ped_lat_q <= ped_lat_d;
            walk_q    <= walk_d;
        end
    end

    assign walk = walk_q;
`else
    logic unused_ped;

    assign unused_ped = ped_req;
    assign demand     = x_lat_q;
    assign cg_min     = GMinM1;
    assign walk       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHg:    if (tick && timer >= GMinM1 && demand) state_d = StHy;
            StHy:    if (tick && timer == YelM1) state_d = StAr1;
            StAr1:   if (tick && timer == ArM1) state_d = StCg;
            StCg:    if (tick && ((timer >= cg_min && !x) || timer == GMaxM1)) state_d = StCy;
            StCy:    if (tick && timer == YelM1) state_d = StAr2;
            StAr2:   if (tick && timer == ArM1) state_d = StHg;
            default: state_d = StHg;
        endcase
    end

    assign enter_cg = (state_d == StCg) && (state_q != StCg);
    assign leave_cg = (state_q == StCg) && (state_d != StCg);

    // A request arriving on the CG entry cycle is dropped; a held x re-latches next cycle.
    assign x_lat_d = enter_cg ? 1'b0 : (x_lat_q | x);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= StHg;
            x_lat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_lat_q <= x_lat_d;
        end
    end

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .clear_n (clear_n),
        .clr_i   (state_d != state_q),
        .tick_i  (tick),
        .count_o (timer)
    );

    assign {hwy, cntry} = tlc_colours(state_q);
    assign phase        = state_q;

endmodule
